// File: rtl/vcr_ovc_ctrl_pkg.sv
// rtl/vcr_ovc_ctrl_pkg.sv - output-VC state encodings shared by the OVC tracker
package vcr_ovc_ctrl_pkg;

  localparam int OVC_STATE_WIDTH = 2;

  typedef enum logic [OVC_STATE_WIDTH-1:0] {
    OVC_STATE_IDLE   = 2'd0,
    OVC_STATE_ACTIVE = 2'd1,
    OVC_STATE_DRAIN  = 2'd2
  } ovc_state_t;

endpackage

// File: rtl/vcr_ovc_state.sv
// rtl/vcr_ovc_state.sv - one output VC: allocation FSM, downstream credit counter, sticky error
import vcr_ovc_ctrl_pkg::*;

module vcr_ovc_state #(
  parameter int buffer_size          = 8,
  parameter int atomic_vc_allocation = 1,
  parameter int cred_width           = $clog2(buffer_size + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic gnt,
  input  logic flit,
  input  logic tail,
  input  logic cred,
  output logic elig,
  output logic free_nonspec,
  output logic empty,
  output logic error
);

  localparam logic [cred_width-1:0] cred_full = cred_width'(buffer_size);
  localparam logic [cred_width-1:0] cred_one  = cred_width'(1);

  ovc_state_t            state, state_n;
  logic [cred_width-1:0] cnt, cnt_n;
  logic                  err;

  // Every event is judged against the registered state and count; an illegal
  // event is dropped and only raises the sticky error.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err     = 1'b0;
    if (gnt) begin
      if (state != OVC_STATE_IDLE) err = 1'b1;
      else                         state_n = OVC_STATE_ACTIVE;
    end
    if (flit) begin
      if (state != OVC_STATE_ACTIVE || cnt == '0) begin
        err = 1'b1;
      end else begin
        cnt_n = cnt - cred_one;
        if (tail) state_n = (atomic_vc_allocation != 0) ? OVC_STATE_DRAIN : OVC_STATE_IDLE;
      end
    end
    if (cred) begin
      if (cnt == cred_full) err = 1'b1;
      else                  cnt_n = cnt_n + cred_one;
    end
    if (state == OVC_STATE_DRAIN && cnt_n == cred_full) state_n = OVC_STATE_IDLE;
  end

  // Outputs are registered from next-state values so they settle one cycle after the event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= OVC_STATE_IDLE;
      cnt          <= cred_full;
      elig         <= 1'b1;
      free_nonspec <= 1'b1;
      empty        <= 1'b1;
      error        <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      elig         <= (state_n == OVC_STATE_IDLE);
      free_nonspec <= (cnt_n != '0);
      empty        <= (cnt_n == cred_full);
      error        <= error | err;
    end
  end

endmodule

// File: rtl/vcr_ovc_ctrl.sv
// rtl/vcr_ovc_ctrl.sv - per-output-port bank of output-VC trackers feeding the allocators
import vcr_ovc_ctrl_pkg::*;

module vcr_ovc_ctrl #(
  parameter int num_message_classes  = 2,
  parameter int num_resource_classes = 2,
  parameter int num_vcs_per_class    = 1,
  parameter int buffer_size          = 8,
  parameter int atomic_vc_allocation = 1,
  parameter int num_vcs              = num_message_classes * num_resource_classes * num_vcs_per_class
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [num_vcs-1:0] vc_gnt_ovc,
  input  logic               flit_valid,
  input  logic               flit_tail,
  input  logic [num_vcs-1:0] flit_sel_ovc,
  input  logic               cred_valid,
  input  logic [num_vcs-1:0] cred_sel_ovc,
  output logic [num_vcs-1:0] elig_ovc,
  output logic [num_vcs-1:0] free_nonspec_ovc,
  output logic [num_vcs-1:0] empty_ovc,
  output logic [num_vcs-1:0] error_ovc
);

  for (genvar i = 0; i < num_vcs; i++) begin : g_ovc
    vcr_ovc_state #(
      .buffer_size          (buffer_size),
      .atomic_vc_allocation (atomic_vc_allocation)
    ) u_ovc_state (
      .clk          (clk),
      .reset        (reset),
      .gnt          (vc_gnt_ovc[i]),
      .flit         (flit_valid & flit_sel_ovc[i]),
      .tail         (flit_tail),
      .cred         (cred_valid & cred_sel_ovc[i]),
      .elig         (elig_ovc[i]),
      .free_nonspec (free_nonspec_ovc[i]),
      .empty        (empty_ovc[i]),
      .error        (error_ovc[i])
    );
  end

endmodule

// File: tb/tb_vcr_ovc_ctrl.sv
// tb/tb_vcr_ovc_ctrl.sv - atomic and non-atomic OVC trackers against a credit/ownership model
module tb_vcr_ovc_ctrl;

  localparam int NV  = 4;
  localparam int BUF = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [NV-1:0] vc_gnt_ovc, flit_sel_ovc, cred_sel_ovc;
  logic          flit_valid, flit_tail, cred_valid;
  logic [NV-1:0] elig_a, free_a, empty_a, error_a;
  logic [NV-1:0] elig_n, free_n, empty_n, error_n;

  int n_checks = 0;
  int n_fail   = 0;

  // model: [0] atomic instance, [1] non-atomic instance
  int credits [2][NV];
  bit owned   [2][NV];
  bit waiting [2][NV];
  bit flagged [2][NV];

  always #5 clk = ~clk;

  vcr_ovc_ctrl #(.num_message_classes(2), .num_resource_classes(2), .num_vcs_per_class(1),
                 .buffer_size(BUF), .atomic_vc_allocation(1)) u_dut_a (
    .clk(clk), .reset(reset), .vc_gnt_ovc(vc_gnt_ovc), .flit_valid(flit_valid),
    .flit_tail(flit_tail), .flit_sel_ovc(flit_sel_ovc), .cred_valid(cred_valid),
    .cred_sel_ovc(cred_sel_ovc), .elig_ovc(elig_a), .free_nonspec_ovc(free_a),
    .empty_ovc(empty_a), .error_ovc(error_a));

  vcr_ovc_ctrl #(.num_message_classes(2), .num_resource_classes(2), .num_vcs_per_class(1),
                 .buffer_size(BUF), .atomic_vc_allocation(0)) u_dut_n (
    .clk(clk), .reset(reset), .vc_gnt_ovc(vc_gnt_ovc), .flit_valid(flit_valid),
    .flit_tail(flit_tail), .flit_sel_ovc(flit_sel_ovc), .cred_valid(cred_valid),
    .cred_sel_ovc(cred_sel_ovc), .elig_ovc(elig_n), .free_nonspec_ovc(free_n),
    .empty_ovc(empty_n), .error_ovc(error_n));

  always @(posedge clk) begin
    if (!reset && flit_valid) assert ($onehot(flit_sel_ovc)) else $error("FAIL onehot flit_sel_ovc %b", flit_sel_ovc);
    if (!reset && cred_valid) assert ($onehot(cred_sel_ovc)) else $error("FAIL onehot cred_sel_ovc %b", cred_sel_ovc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < NV; i++) begin
        credits[m][i] = BUF; owned[m][i] = 0; waiting[m][i] = 0; flagged[m][i] = 0;
      end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < NV; i++) begin
        bit was_owned   = owned[m][i];
        bit was_waiting = waiting[m][i];
        int had         = credits[m][i];
        if (vc_gnt_ovc[i]) begin
          if (was_owned || was_waiting) flagged[m][i] = 1;
          else owned[m][i] = 1;
        end
        if (flit_valid && flit_sel_ovc[i]) begin
          if (!was_owned || had == 0) flagged[m][i] = 1;
          else begin
            credits[m][i]--;
            if (flit_tail) begin owned[m][i] = 0; waiting[m][i] = (m == 0); end
          end
        end
        if (cred_valid && cred_sel_ovc[i]) begin
          if (had == BUF) flagged[m][i] = 1;
          else credits[m][i]++;
        end
        if (was_waiting && credits[m][i] == BUF) waiting[m][i] = 0;
      end
  endtask

  function automatic logic [31:0] exp_vec(input int m, input int kind);
    logic [31:0] v = '0;
    for (int i = 0; i < NV; i++)
      case (kind)
        0:       v[i] = !owned[m][i] && !waiting[m][i];
        1:       v[i] = credits[m][i] > 0;
        2:       v[i] = credits[m][i] == BUF;
        default: v[i] = flagged[m][i];
      endcase
    return v;
  endfunction

  task automatic compare_all();
    check("elig_a",  {28'd0, elig_a},  exp_vec(0, 0));
    check("free_a",  {28'd0, free_a},  exp_vec(0, 1));
    check("empty_a", {28'd0, empty_a}, exp_vec(0, 2));
    check("error_a", {28'd0, error_a}, exp_vec(0, 3));
    check("elig_n",  {28'd0, elig_n},  exp_vec(1, 0));
    check("free_n",  {28'd0, free_n},  exp_vec(1, 1));
    check("empty_n", {28'd0, empty_n}, exp_vec(1, 2));
    check("error_n", {28'd0, error_n}, exp_vec(1, 3));
  endtask

  task automatic idle_inputs();
    vc_gnt_ovc = '0; flit_valid = 0; flit_tail = 0; flit_sel_ovc = '0;
    cred_valid = 0; cred_sel_ovc = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset(); else model_step();
    #1;
    compare_all();
    idle_inputs();
  endtask

  task automatic do_reset();
    reset = 1; idle_inputs();
    tick(); tick();
    reset = 0;
  endtask

  task automatic grant(input int v);
    vc_gnt_ovc = NV'(1 << v); tick();
  endtask

  task automatic send_flit(input int v, input bit tl);
    flit_valid = 1; flit_sel_ovc = NV'(1 << v); flit_tail = tl; tick();
  endtask

  task automatic send_cred(input int v);
    cred_valid = 1; cred_sel_ovc = NV'(1 << v); tick();
  endtask

  initial begin
    reset = 1; idle_inputs();
    model_reset();
    #1;
    tick(); tick();
    reset = 0;
    check("rst_elig",  {28'd0, elig_a},  32'hf);
    check("rst_free",  {28'd0, free_a},  32'hf);
    check("rst_empty", {28'd0, empty_a}, 32'hf);
    check("rst_error", {28'd0, error_a}, 32'h0);

    // packet of three flits on OVC1, then three credits
    grant(1);
    check("gnt_elig1_low", 32'(elig_a[1]), 32'd0);
    send_flit(1, 0); send_flit(1, 0); send_flit(1, 1);
    check("drain_empty1", 32'(empty_a[1]), 32'd0);
    check("drain_elig1_a", 32'(elig_a[1]), 32'd0);
    check("tail_elig1_n", 32'(elig_n[1]), 32'd1);
    send_cred(1); send_cred(1);
    check("drain_hold_elig1", 32'(elig_a[1]), 32'd0);
    send_cred(1);
    check("drain_done_elig1", 32'(elig_a[1]), 32'd1);
    check("drain_done_empty1", 32'(empty_a[1]), 32'd1);

    // underflow on OVC0
    do_reset();
    grant(0);
    for (int k = 0; k < BUF; k++) send_flit(0, 0);
    check("uf_free0", 32'(free_a[0]), 32'd0);
    check("uf_err0_pre", 32'(error_a[0]), 32'd0);
    send_flit(0, 0);
    check("uf_err0", 32'(error_a[0]), 32'd1);
    check("uf_free0_hold", 32'(free_a[0]), 32'd0);
    send_cred(0);
    flit_valid = 1; flit_sel_ovc = 4'b0001; cred_valid = 1; cred_sel_ovc = 4'b0001; tick();
    check("fc_free0", 32'(free_a[0]), 32'd1);
    send_flit(0, 0);
    check("fc_count1", 32'(free_a[0]), 32'd0);

    // overflow on idle OVC2, double grant on OVC0
    do_reset();
    send_cred(2);
    check("of_err2", 32'(error_a[2]), 32'd1);
    check("of_empty2", 32'(empty_a[2]), 32'd1);
    grant(0); grant(0);
    check("dg_err0", 32'(error_a[0]), 32'd1);
    check("dg_elig0", 32'(elig_a[0]), 32'd0);
    send_flit(0, 1);
    check("dg_still_active", 32'(empty_a[0]), 32'd0);

    // asynchronous reset while OVC3 drains
    do_reset();
    grant(3);
    send_flit(3, 0); send_flit(3, 0); send_flit(3, 1);
    check("pre_rst_elig3", 32'(elig_a[3]), 32'd0);
    reset = 1;
    #1;
    model_reset();
    compare_all();
    check("async_elig",  {28'd0, elig_a},  32'hf);
    check("async_empty", {28'd0, empty_a}, 32'hf);
    tick();
    reset = 0;
    send_cred(3);
    check("late_cred_err3", 32'(error_a[3]), 32'd1);

    // random traffic with periodic reset
    for (int c = 0; c < 600; c++) begin
      if (c % 60 == 59) reset = 1;
      else begin
        reset = 0;
        if ($urandom_range(0, 2) == 0) vc_gnt_ovc = NV'(1 << $urandom_range(0, NV - 1));
        flit_valid   = $urandom_range(0, 1) == 1;
        flit_sel_ovc = NV'(1 << $urandom_range(0, NV - 1));
        flit_tail    = $urandom_range(0, 3) == 0;
        cred_valid   = $urandom_range(0, 1) == 1;
        cred_sel_ovc = NV'(1 << $urandom_range(0, NV - 1));
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
